imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that writes the instruction memory read by the pipeline fetch stage. It accepts a framed byte stream (length, payload, checksum) over a valid/ready handshake, writes payload bytes to consecutive instruction-memory byte addresses from 0, and holds the CPU (PC and IF/ID) stalled until a frame loads and verifies correctly.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory byte-address width.
- `MAX_WORDS`, 64: largest legal frame length in 32-bit words. 4*MAX_WORDS must be ≤ 2^ADDR_W.

Ports:
- `clk`  in  1  rising-edge clock; the block uses one clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins frame reception.
- `in_valid`  in  1  stream byte valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  block can accept a byte.
- `mem_we`  out  1  instruction-memory byte write strobe.
- `mem_addr`  out  ADDR_W  write byte address.
- `mem_wdata`  out  8  write data.
- `cpu_hold`  out  1  drives PC/IF-ID enable low while high.
- `done`  out  1  last frame loaded and verified.
- `err`  out  1  last frame rejected.
- `words_loaded`  out  7  payload words written in the current or last frame.

## Operation
- States:
  - IDLE: entered on reset.
  - LEN: waiting for the length byte.
  - DATA: receiving payload bytes.
  - CSUM: waiting for the checksum byte.
  - DONE: frame verified.
  - ERR: frame rejected.
- Handshake: a byte transfers on a rising edge with `in_valid && in_ready`.
  - `in_ready` is a combinational decode of state: high in LEN, DATA and CSUM, low elsewhere.
  - The producer may drop `in_valid` at any time. Gaps stall the block without side effects.
- `start`:
  - Accepted in IDLE, DONE and ERR. Goes to LEN.
  - Clears `done`, `err`, `words_loaded`, the byte counter and the checksum accumulator.
  - Sets `cpu_hold` to 1.
  - Ignored in LEN, DATA and CSUM.
- LEN, on accepted byte N:
  - If 1 ≤ N ≤ MAX_WORDS: latch N, go to DATA.
  - Otherwise: go to ERR. No memory write occurs.
- DATA, for the k-th accepted byte (k = 0..4N-1):
  - Write `in_data` to byte address k, so stream order equals big-endian word order at addresses 4w..4w+3.
  - Fold the byte into the checksum: acc ^= byte.
  - `words_loaded` increments after every 4th byte.
  - Acceptance of byte 4N-1 moves the block to CSUM.
  - The address counter never wraps: the length check bounds the last address to 4*MAX_WORDS-1.
- CSUM, on accepted byte:
  - If the byte equals acc: go to DONE, `done`=1, `cpu_hold`=0.
  - Otherwise: go to ERR, `err`=1, `cpu_hold` stays 1.
- Memory already written is never undone. ERR relies on `cpu_hold` to keep the CPU from fetching the bad image.

## Timing
- Reset values: state IDLE, `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=1, `done`=0, `err`=0, `words_loaded`=0.
- Write path is registered with 1-cycle latency: a byte accepted at edge t appears as `mem_we`=1 with its `mem_addr`/`mem_wdata` for exactly the cycle after edge t.
  - `mem_addr` and `mem_wdata` hold their last values when `mem_we`=0.
- Back-to-back accepts give one write per cycle. The sustained rate is 1 byte/cycle.
- `done`/`err`/`cpu_hold` update on the edge that accepts the checksum (or the rejected length) byte.
  - The final payload write (`mem_we` in the cycle after the last DATA accept) completes before `cpu_hold` falls, so the PC never sees a partial image.
- DONE and ERR persist until `start` or reset.
- Reset asserted mid-frame asynchronously forces all reset values, including dropping an in-flight `mem_we`. Partially written memory contents are left as is.
- `start` on the same edge as an accepted byte in LEN/DATA/CSUM is ignored; the byte is processed normally.

## Test plan
- Frame 01, E3, A0, 10, 05, 56 streamed continuously after `start`:
  - Writes E3/A0/10/05 to addresses 0..3 on consecutive cycles.
  - Then `done`=1, `cpu_hold`=0, `words_loaded`=1, `err`=0.
- Length byte 00, and separately 41 (65):
  - `err`=1, no `mem_we` pulse, `cpu_hold`=1.
  - `in_ready`=0 afterward until `start`.
- Frame 01, E3, A0, 10, 05, 57: all four writes occur, then `err`=1, `done`=0, `cpu_hold`=1.
- Same frame with `in_valid` low for 3 cycles between every byte:
  - Identical writes and result.
  - No `mem_we` during gaps; address sequence 0,1,2,3 with no skips.
- Reset pulsed low after the 2nd payload byte:
  - Outputs return to reset values immediately; in-flight `mem_we` is cleared.
  - A fresh `start` plus full frame then loads correctly.
- N=64 with payload bytes 00..FF:
  - Last write is address 255 (FF); no wrap to 0.
  - Checksum 00 yields `done`=1, `words_loaded`=64.
- A `start` received in DONE returns the block to LEN with `cpu_hold`=1.

Source files
------------

// File: rtl/imem_loader_if.sv
// Loader bus: framed byte stream in (valid/ready) and instruction-memory
// byte-write port out. The master side is the producer/memory system,
// the slave side is the loader.
//
// Handshake: a byte transfers on a rising clk edge where in_valid and
// in_ready are both high. The producer may drop in_valid at any time;
// in_ready depends only on loader state, never on in_valid.
interface imem_loader_if #(
   parameter int ADDR_W = 8
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory program loader. Receives a frame (length in words,
// 4*length payload bytes, XOR checksum), writes the payload to byte
// addresses 0.. and keeps the CPU held until a frame verifies.
module imem_loader #(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   imem_loader_if.slave bus,
   output logic         cpu_hold,
   output logic         done,
   output logic         err,
   output logic [6:0]   words_loaded,
   output logic [2:0]   dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN  = 3'd1,
      S_DATA = 3'd2,
      S_CSUM = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   localparam logic [7:0] MAX_LEN = 8'(MAX_WORDS);

   state_t            state;
   state_t            state_nxt;
   logic [6:0]        len_q;
   logic [ADDR_W-1:0] byte_cnt;
   logic [7:0]        acc;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [7:0]        mem_wdata_q;

   logic accept;
   logic start_ok;
   logic len_ok;
   logic last_byte;
   logic csum_ok;

   assign bus.in_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
   assign accept       = bus.in_valid && bus.in_ready;
   assign start_ok     = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
   assign len_ok       = (bus.in_data != 8'd0) && (bus.in_data <= MAX_LEN);
   // The last payload byte closes the final word of the frame; the length
   // check keeps its address at or below 4*MAX_WORDS-1, so no wrap.
   assign last_byte    = (byte_cnt[1:0] == 2'b11) && ((words_loaded + 7'd1) == len_q);
   assign csum_ok      = (bus.in_data == acc);

   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign dbg_state     = state;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode from the current state, start and accepted byte.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE, S_ERR: if (start)  state_nxt = S_LEN;
         S_LEN:                 if (accept) state_nxt = len_ok ? S_DATA : S_ERR;
         S_DATA:                if (accept && last_byte) state_nxt = S_CSUM;
         S_CSUM:                if (accept) state_nxt = csum_ok ? S_DONE : S_ERR;
         default:               state_nxt = S_IDLE;
      endcase
   end

   // Datapath: length latch, byte counter, checksum, registered write port, status.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         len_q        <= '0;
         byte_cnt     <= '0;
         acc          <= '0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_hold     <= 1'b1;
         done         <= 1'b0;
         err          <= 1'b0;
         words_loaded <= '0;
      end else begin
         mem_we_q <= 1'b0;
         if (start_ok) begin
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            byte_cnt     <= '0;
            acc          <= '0;
            cpu_hold     <= 1'b1;
         end
         if (accept) begin
            case (state)
               S_LEN: begin
                  if (len_ok) len_q <= bus.in_data[6:0];
                  else        err   <= 1'b1;
               end
               S_DATA: begin
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= byte_cnt;
                  mem_wdata_q <= bus.in_data;
                  acc         <= acc ^ bus.in_data;
                  byte_cnt    <= byte_cnt + 1'b1;
                  if (byte_cnt[1:0] == 2'b11) words_loaded <= words_loaded + 7'd1;
               end
               S_CSUM: begin
                  // cpu_hold only releases on a verified image.
                  if (csum_ok) begin
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     err <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of framed loads, hand-written corner
// sequences (write latency, ignored start, mid-frame reset) and random
// frames checked against a frame-level reference model.
module tb_imem_loader;

   localparam int ADDR_W    = 8;
   localparam int MAX_WORDS = 64;
   localparam int W         = ADDR_W + 8;

   // ---------------- clock / reset ----------------
   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       cpu_hold;
   logic       done;
   logic       err;
   logic [6:0] words_loaded;
   logic [2:0] dbg_state;

   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .bus          (bus),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded),
      .dbg_state    (dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   logic [7:0]   frame_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Every memory write must match the next expected {addr, data}.
   always @(negedge clk) begin
      if (reset === 1'b1 && bus.mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                     bus.mem_addr, bus.mem_wdata);
         end else begin
            chk("mem_write", {16'd0, bus.mem_addr, bus.mem_wdata}, {16'd0, exp_q.pop_front()});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         start        = 1'b0;
         bus.in_valid = 1'b0;
      end
   endtask

   // Present one byte and return on the edge that accepts it.
   task automatic send_byte(input logic [7:0] b, input logic with_start);
      int n = 0;
      @(negedge clk);
      start        = with_start;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      while (bus.in_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready %b after 20 cycles, required 1", bus.in_ready);
         bus.in_valid = 1'b0;
         start        = 1'b0;
      end else begin
         @(posedge clk);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start        = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("start_in_ready", bus.in_ready, 1);
      chk("start_cpu_hold", cpu_hold, 1);
      chk("start_done", done, 0);
      chk("start_err", err, 0);
      chk("start_words", words_loaded, 0);
   endtask

   task automatic check_reset_values();
      chk("rst_state", dbg_state, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_cpu_hold", cpu_hold, 1);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_words", words_loaded, 0);
   endtask

   // Stream frame_q (len, payload, csum) after a start and check the outcome.
   task automatic run_frame(input int gmax, input bit rand_gap, input logic exp_done,
                            input logic exp_err, input logic [6:0] exp_words);
      int len;
      int g;
      pulse_start();
      len = int'(frame_q[0]);
      send_byte(frame_q[0], 1'b0);
      if (len >= 1 && len <= MAX_WORDS) begin
         for (int k = 0; k < 4 * len; k++) begin
            g = rand_gap ? int'($urandom_range(0, gmax)) : gmax;
            idle(g);
            exp_q.push_back({ADDR_W'(k), frame_q[1 + k]});
            send_byte(frame_q[1 + k], 1'b0);
         end
         g = rand_gap ? int'($urandom_range(0, gmax)) : gmax;
         idle(g);
         send_byte(frame_q[4 * len + 1], 1'b0);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("frame_done", done, exp_done);
      chk("frame_err", err, exp_err);
      chk("frame_cpu_hold", cpu_hold, !exp_done);
      chk("frame_words", words_loaded, exp_words);
      chk("frame_in_ready", bus.in_ready, 0);
      chk("frame_writes_left", exp_q.size(), 0);
      idle(3);
      chk("frame_in_ready_hold", bus.in_ready, 0);
      chk("frame_done_hold", done, exp_done);
   endtask

   // Reference model: frame outcome from the length rule and XOR checksum.
   function automatic void model(output logic d, output logic e, output logic [6:0] w);
      int n;
      logic [7:0] x;
      n = int'(frame_q[0]);
      x = 8'd0;
      if (n < 1 || n > MAX_WORDS) begin
         d = 1'b0; e = 1'b1; w = 7'd0;
      end else begin
         for (int k = 0; k < 4 * n; k++) x = x ^ frame_q[1 + k];
         d = (frame_q[4 * n + 1] == x);
         e = !d;
         w = 7'(n);
      end
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0]  len;
      logic [31:0] word0;   // first four payload bytes, big-endian; later bytes = address
      logic [7:0]  csum;
      int          gap;
      logic        exp_done;
      logic        exp_err;
      logic [6:0]  exp_words;
   } vec_t;

   vec_t vecs[8];

   task automatic build_vec_frame(input vec_t v);
      logic [7:0] b;
      frame_q.delete();
      frame_q.push_back(v.len);
      if (v.len >= 8'd1 && v.len <= 8'(MAX_WORDS)) begin
         for (int k = 0; k < 4 * int'(v.len); k++) begin
            if (k < 4) b = v.word0[31 - 8 * k -: 8];
            else       b = 8'(k);
            frame_q.push_back(b);
         end
         frame_q.push_back(v.csum);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       m_d;
      logic       m_e;
      logic [6:0] m_w;
      logic [7:0] x;
      int         len;

      vecs[0] = '{8'h01, 32'hE3A01005, 8'h56, 0, 1'b1, 1'b0, 7'd1};
      vecs[1] = '{8'h00, 32'h0,        8'h00, 0, 1'b0, 1'b1, 7'd0};
      vecs[2] = '{8'h41, 32'h0,        8'h00, 0, 1'b0, 1'b1, 7'd0};
      vecs[3] = '{8'h01, 32'hE3A01005, 8'h57, 0, 1'b0, 1'b1, 7'd1};
      vecs[4] = '{8'h01, 32'hE3A01005, 8'h56, 3, 1'b1, 1'b0, 7'd1};
      vecs[5] = '{8'h02, 32'hDEADBEEF, 8'h22, 1, 1'b1, 1'b0, 7'd2};
      vecs[6] = '{8'hFF, 32'h0,        8'h00, 0, 1'b0, 1'b1, 7'd0};
      vecs[7] = '{8'h40, 32'h00010203, 8'h00, 0, 1'b1, 1'b0, 7'd64};

      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      @(negedge clk);
      check_reset_values();
      @(negedge clk);
      reset = 1'b1;
      idle(2);
      check_reset_values();

      for (int i = 0; i < 8; i++) begin
         build_vec_frame(vecs[i]);
         run_frame(vecs[i].gap, 1'b0, vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_words);
      end
      // Last table frame filled all 256 bytes: the port holds address FF.
      chk("full_last_addr", bus.mem_addr, 8'hFF);
      chk("full_last_data", bus.mem_wdata, 8'hFF);

      // Write latency, start ignored mid-frame (alone and with an accept).
      pulse_start();
      send_byte(8'h01, 1'b0);
      exp_q.push_back({8'h00, 8'hE3});
      send_byte(8'hE3, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("lat_we", bus.mem_we, 1);
      chk("lat_addr", bus.mem_addr, 0);
      chk("lat_data", bus.mem_wdata, 8'hE3);
      @(negedge clk);
      chk("lat_we_gap", bus.mem_we, 0);
      chk("lat_addr_hold", bus.mem_addr, 0);
      exp_q.push_back({8'h01, 8'hA0});
      send_byte(8'hA0, 1'b1);
      idle(1);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ign_in_ready", bus.in_ready, 1);
      exp_q.push_back({8'h02, 8'h10});
      send_byte(8'h10, 1'b0);
      exp_q.push_back({8'h03, 8'h05});
      send_byte(8'h05, 1'b0);
      send_byte(8'h56, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("ign_done", done, 1);
      chk("ign_cpu_hold", cpu_hold, 0);
      chk("ign_words", words_loaded, 1);

      // Reset mid-frame right after the second payload byte is accepted.
      pulse_start();
      send_byte(8'h01, 1'b0);
      exp_q.push_back({8'h00, 8'hE3});
      send_byte(8'hE3, 1'b0);
      exp_q.push_back({8'h01, 8'hA0});
      send_byte(8'hA0, 1'b0);
      #1;
      reset = 1'b0;
      exp_q.delete();
      bus.in_valid = 1'b0;
      #1;
      check_reset_values();
      @(negedge clk);
      reset = 1'b1;
      build_vec_frame(vecs[0]);
      run_frame(0, 1'b0, 1'b1, 1'b0, 7'd1);

      // Random frames against the model.
      for (int r = 0; r < 25; r++) begin
         frame_q.delete();
         if ($urandom_range(0, 3) == 0) len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(65, 255));
         else                           len = int'($urandom_range(1, 6));
         frame_q.push_back(8'(len));
         if (len >= 1 && len <= MAX_WORDS) begin
            x = 8'd0;
            for (int k = 0; k < 4 * len; k++) begin
               frame_q.push_back(8'($urandom_range(0, 255)));
               x = x ^ frame_q[1 + k];
            end
            if ($urandom_range(0, 1) == 0) frame_q.push_back(x);
            else                           frame_q.push_back(x ^ 8'($urandom_range(1, 255)));
         end
         model(m_d, m_e, m_w);
         run_frame(2, 1'b1, m_d, m_e, m_w);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
